// File: rtl/conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl
//
// Sequencer for the KxK sliding-window generator in the convolution path.
// A start pulse raster-scans one IMG_W x IMG_H feature map out of the
// single-port frame RAM, one pixel per cycle. Each RAM beat is announced with
// pix_valid (the window generator's shift enable). Whenever the pixel on
// pix_valid completes a full KxK window that lies on the stride grid,
// win_valid is raised together with the window's output-map coordinates.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   one-cycle scan request, accepted only while idle
//   stride     in   window stride (0 behaves as 1), latched on accepted start
//   ready      in   downstream can accept window data; gates RAM reads
//   rd_en      out  frame-RAM read enable
//   rd_addr    out  frame-RAM read address, row-major
//   pix_valid  out  RAM data valid this cycle (rd_en delayed one cycle)
//   win_valid  out  current pixel completes a stride-aligned full window
//   win_row    out  output-map row of the window (0 unless win_valid)
//   win_col    out  output-map column of the window (0 unless win_valid)
//   busy       out  scan in progress
//   done       out  one-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module conv_window_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        stride,
    input  logic              ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              win_valid,
    output logic [CNT_W-1:0]  win_row,
    output logic [CNT_W-1:0]  win_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0]  C_KM1       = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]  C_COL_LAST  = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]  C_ROW_LAST  = CNT_W'(IMG_H - 1);

    state_t             r_state;
    state_t             w_next;

    logic [1:0]         r_stride;     // latched stride, always 1..3
    logic [ADDR_W-1:0]  r_addr;       // next address to issue
    logic               r_pix_valid;  // RAM data valid (rd_en delayed)

    // Coordinate of the pixel currently carried by pix_valid.
    logic [CNT_W-1:0]   r_pr;
    logic [CNT_W-1:0]   r_pc;

    // Stride phase and output-map index of the current row / column. The
    // phase is (coord-(K-1)) mod stride and the index is (coord-(K-1))/stride,
    // maintained incrementally so no divider is needed.
    logic [1:0]         r_row_ph;
    logic [1:0]         r_col_ph;
    logic [CNT_W-1:0]   r_win_row;
    logic [CNT_W-1:0]   r_win_col;

    logic               w_start_acc;
    logic               w_issue;
    logic [1:0]         w_ph_max;
    logic               w_row_full;
    logic               w_col_full;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_issue     = (r_state == S_FETCH) && ready;
    assign w_ph_max    = r_stride - 2'd1;
    assign w_row_full  = (r_pr >= C_KM1);
    assign w_col_full  = (r_pc >= C_KM1);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and control outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        rd_en  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy  = 1'b1;
                rd_en = ready;
                if (ready && (r_addr == C_LAST_ADDR)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last read is still in flight; its data shows up on
                // pix_valid in this cycle.
                busy   = 1'b1;
                w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address generator and stride latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_stride <= 2'd0;
        end else if (w_start_acc) begin
            r_addr   <= '0;
            r_stride <= (stride == 2'd0) ? 2'd1 : stride;
        end else if (w_issue && (r_addr != C_LAST_ADDR)) begin
            // A stalled cycle leaves the address alone, so no address is
            // skipped or repeated however ready toggles.
            r_addr <= r_addr + 1'b1;
        end
    end

    assign rd_addr = r_addr;

    // -------------------------------------------------------------------------
    // RAM data valid: one-cycle read latency, independent of ready
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= rd_en;
        end
    end

    assign pix_valid = r_pix_valid;

    // -------------------------------------------------------------------------
    // Pixel and window coordinate counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pr      <= '0;
            r_pc      <= '0;
            r_row_ph  <= 2'd0;
            r_col_ph  <= 2'd0;
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_start_acc) begin
            r_pr      <= '0;
            r_pc      <= '0;
            r_row_ph  <= 2'd0;
            r_col_ph  <= 2'd0;
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (r_pix_valid) begin
            if (r_pc == C_COL_LAST) begin
                // End of row: column tracking restarts, so a window can never
                // straddle the wrap (pc < K-1 at row start suppresses it).
                r_pc      <= '0;
                r_col_ph  <= 2'd0;
                r_win_col <= '0;
                if (r_pr != C_ROW_LAST) begin
                    r_pr <= r_pr + 1'b1;
                    if (w_row_full) begin
                        if (r_row_ph == w_ph_max) begin
                            r_row_ph  <= 2'd0;
                            r_win_row <= r_win_row + 1'b1;
                        end else begin
                            r_row_ph <= r_row_ph + 2'd1;
                        end
                    end
                end
            end else begin
                r_pc <= r_pc + 1'b1;
                if (w_col_full) begin
                    if (r_col_ph == w_ph_max) begin
                        r_col_ph  <= 2'd0;
                        r_win_col <= r_win_col + 1'b1;
                    end else begin
                        r_col_ph <= r_col_ph + 2'd1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Window-valid decode; coordinates are forced to 0 outside win_valid
    // -------------------------------------------------------------------------
    assign win_valid = r_pix_valid && w_row_full && w_col_full &&
                       (r_row_ph == 2'd0) && (r_col_ph == 2'd0);
    assign win_row   = win_valid ? r_win_row : '0;
    assign win_col   = win_valid ? r_win_col : '0;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for conv_window_ctrl on an 8x8 map with a 5x5 kernel.
// Expected read addresses and windows are pushed to queues before each scan
// and popped as the DUT produces them; control outputs are checked per cycle
// against a small cycle model kept by the bench.
// -----------------------------------------------------------------------------
module tb_conv_window_ctrl;

    localparam int W      = 8;
    localparam int H      = 8;
    localparam int KK     = 5;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 5;
    localparam int NPIX   = W * H;

    typedef struct {
        int idx;
        int row;
        int col;
    } win_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        stride;
    logic              ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pix_valid;
    logic              win_valid;
    logic [CNT_W-1:0]  win_row;
    logic [CNT_W-1:0]  win_col;
    logic              busy;
    logic              done;

    int   total;
    int   bad;
    int   addr_q[$];
    win_t win_q[$];

    conv_window_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .K     (KK),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stride   (stride),
        .ready    (ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .pix_valid(pix_valid),
        .win_valid(win_valid),
        .win_row  (win_row),
        .win_col  (win_col),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // One full scan with per-cycle checking.
    //   mode 0: ready low for cycles lo..hi; mode 1: ready high on odd cycles
    //   restart_at: cycle in which start is re-pulsed with stride 2 (-1: never)
    // -------------------------------------------------------------------------
    task automatic run_scan(input string name, input logic [1:0] s,
                            input int mode, input int lo, input int hi,
                            input int restart_at, input int exp_done,
                            input int exp_wins);
        int   st;
        int   cyc;
        int   pix_cnt;
        int   wins;
        int   dones;
        int   done_cyc;
        int   want_addr;
        int   want_row;
        int   want_col;
        logic exp_rd;
        logic prev_rd;
        logic exp_pv;
        logic exp_wv;
        logic exp_busy;
        logic exp_dn;
        win_t w;
        win_t hit;

        st = (s == 2'd0) ? 1 : int'(s);
        addr_q.delete();
        win_q.delete();
        for (int a = 0; a < NPIX; a++) addr_q.push_back(a);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r >= KK - 1 && c >= KK - 1 &&
                    (r - (KK - 1)) % st == 0 && (c - (KK - 1)) % st == 0) begin
                    w.idx = r * W + c;
                    w.row = (r - (KK - 1)) / st;
                    w.col = (c - (KK - 1)) / st;
                    win_q.push_back(w);
                end
            end
        end

        @(posedge clk);
        #1;
        start    = 1'b1;
        stride   = s;
        ready    = 1'b1;
        cyc      = 0;
        prev_rd  = 1'b0;
        pix_cnt  = 0;
        wins     = 0;
        dones    = 0;
        done_cyc = -1;

        while (cyc < exp_done + 3 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start  = (cyc == restart_at);
            stride = (cyc == restart_at) ? 2'd2 : s;
            ready  = (mode == 0) ? !(cyc >= lo && cyc <= hi) : (cyc % 2 == 1);
            @(negedge clk);

            exp_rd = (addr_q.size() > 0) && ready;
            total++;
            if (rd_en !== exp_rd) begin
                bad++;
                $display("FAIL %s rd_en cyc=%0d got=%b want=%b", name, cyc, rd_en, exp_rd);
            end
            if (exp_rd) begin
                want_addr = addr_q.pop_front();
                total++;
                if (int'(rd_addr) != want_addr) begin
                    bad++;
                    $display("FAIL %s rd_addr cyc=%0d got=%0d want=%0d", name, cyc, rd_addr, want_addr);
                end
                if (addr_q.size() == 0) done_cyc = cyc + 2;
            end

            exp_pv  = prev_rd;
            prev_rd = exp_rd;
            total++;
            if (pix_valid !== exp_pv) begin
                bad++;
                $display("FAIL %s pix_valid cyc=%0d got=%b want=%b", name, cyc, pix_valid, exp_pv);
            end

            exp_wv   = 1'b0;
            want_row = 0;
            want_col = 0;
            if (exp_pv && win_q.size() > 0 && win_q[0].idx == pix_cnt) begin
                hit      = win_q.pop_front();
                exp_wv   = 1'b1;
                want_row = hit.row;
                want_col = hit.col;
            end
            if (exp_pv) pix_cnt++;
            total++;
            if (win_valid !== exp_wv) begin
                bad++;
                $display("FAIL %s win_valid cyc=%0d got=%b want=%b", name, cyc, win_valid, exp_wv);
            end
            total++;
            if (int'(win_row) != want_row || int'(win_col) != want_col) begin
                bad++;
                $display("FAIL %s win_coord cyc=%0d got=(%0d,%0d) want=(%0d,%0d)",
                         name, cyc, win_row, win_col, want_row, want_col);
            end
            if (win_valid === 1'b1) wins++;

            exp_busy = (done_cyc < 0) || (cyc < done_cyc);
            exp_dn   = (cyc == done_cyc);
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, busy, exp_busy);
            end
            total++;
            if (done !== exp_dn) begin
                bad++;
                $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, done, exp_dn);
            end
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        ready = 1'b1;

        total++;
        if (done_cyc != exp_done) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, exp_done);
        end
        total++;
        if (wins != exp_wins) begin
            bad++;
            $display("FAIL %s window_count got=%0d want=%0d", name, wins, exp_wins);
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_pulses got=%0d want=1", name, dones);
        end
        total++;
        if (addr_q.size() != 0 || win_q.size() != 0) begin
            bad++;
            $display("FAIL %s leftover got=addr:%0d,win:%0d want=0,0", name, addr_q.size(), win_q.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (rd_en !== 1'b0 || rd_addr !== '0 || pix_valid !== 1'b0 ||
            win_valid !== 1'b0 || win_row !== '0 || win_col !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s outputs got=rd_en:%b addr:%0d pv:%b wv:%b row:%0d col:%0d busy:%b done:%b want=all 0",
                     name, rd_en, rd_addr, pix_valid, win_valid, win_row, win_col, busy, done);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        stride = 2'd1;
        ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_stride1();
        run_scan("stride1", 2'd1, 0, -1, -1, -1, 66, 16);
    endtask

    task automatic test_stride2();
        run_scan("stride2", 2'd2, 0, -1, -1, -1, 66, 4);
    endtask

    task automatic test_stride0();
        run_scan("stride0", 2'd0, 0, -1, -1, -1, 66, 16);
    endtask

    task automatic test_backpressure();
        run_scan("backpressure", 2'd1, 0, 10, 19, -1, 76, 16);
    endtask

    task automatic test_ready_toggle();
        run_scan("ready_toggle", 2'd3, 1, -1, -1, -1, 129, 4);
    endtask

    task automatic test_restart_ignored();
        run_scan("restart_busy", 2'd1, 0, -1, -1, 30, 66, 16);
    endtask

    task automatic test_start_in_fin();
        run_scan("start_in_fin", 2'd1, 0, -1, -1, 66, 66, 16);
    endtask

    task automatic test_abort_reset();
        int dn;
        @(posedge clk);
        #1;
        start  = 1'b1;
        stride = 2'd1;
        ready  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_precond got=busy:%b pv:%b want=1,1", busy, pix_valid);
        end
        rst = 1'b1;
        #1;
        check_all_zero("abort_same_cycle");
        @(posedge clk);
        #1;
        rst = 1'b0;
        dn  = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d active cycles want=0", dn);
        end
        run_scan("after_abort", 2'd1, 0, -1, -1, -1, 66, 16);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stride1();
        test_stride2();
        test_stride0();
        test_backpressure();
        test_ready_toggle();
        test_restart_ignored();
        test_start_in_fin();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencer for the 5x5 sliding-window generator in the CNN convolution path.
- On a start pulse it raster-scans one feature map out of the single-port frame RAM, one pixel per cycle.
- Emits a pixel strobe that shifts the window generator's line buffers, and a window-valid strobe with the window's output coordinates whenever the 5x5 window is complete and lands on the stride grid.
- Honours downstream backpressure and reports busy/done to the layer controller.

Parameters:
- IMG_W, 28, feature-map width in pixels
- IMG_H, 28, feature-map height in pixels
- K, 5, kernel size; must match the window generator
- ADDR_W, 10, frame-RAM address width; IMG_W*IMG_H <= 2**ADDR_W
- CNT_W, 5, row/column counter width; holds IMG_W-1 and IMG_H-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to scan a map; ignored unless idle
- stride  in  2  window stride, latched on accepted start; 0 is treated as 1; legal values 1..3
- ready  in  1  downstream can accept window data
- rd_en  out  1  frame-RAM read enable
- rd_addr  out  ADDR_W  frame-RAM read address, row-major
- pix_valid  out  1  RAM data valid this cycle; drives the window generator's shift enable
- win_valid  out  1  window generator output is a stride-aligned full window
- win_row  out  CNT_W  output-map row of the current window
- win_col  out  CNT_W  output-map column of the current window
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, scan complete

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; every output and internal counter 0.
- Reset asserted mid-scan aborts immediately: back to IDLE, no done pulse.
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE:
  - start=1 latches the stride (0 becomes 1) and clears rd_addr, row and column counters.
  - Next state FETCH; busy=1 from the next cycle.
- FETCH:
  - rd_en = ready.
  - Each cycle rd_en=1, rd_addr increments by 1.
  - When rd_addr = IMG_W*IMG_H-1 is issued, next state is DRAIN.
- DRAIN: rd_en=0, waits one cycle for the last RAM beat, then FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- RAM timing: read latency is 1 cycle. pix_valid is rd_en registered once and is independent of ready.
- Backpressure: the consumer must absorb exactly one in-flight beat after deasserting ready.
- Pixel counters pr, pc:
  - Track the coordinate of the pixel carried by pix_valid.
  - pc increments on each pix_valid and wraps to 0 at IMG_W-1, which also increments pr.
  - pr stops at IMG_H-1.
- win_valid = pix_valid && pr>=K-1 && pc>=K-1 && (pr-(K-1)) mod stride == 0 && (pc-(K-1)) mod stride == 0.
- Window coordinates:
  - win_row = (pr-(K-1))/stride and win_col = (pc-(K-1))/stride.
  - Implement these with secondary counters, not dividers.
  - They are valid only when win_valid=1 and read 0 otherwise.
- Window count: floor((IMG_H-K)/stride)+1 by floor((IMG_W-K)/stride)+1. Windows never straddle a row wrap; pc<K-1 at the start of a row suppresses them.
- Simultaneous events:
  - start during busy is ignored; the latched stride is unchanged.
  - start in the FIN cycle is ignored.
  - ready toggling every cycle is legal; addresses are never skipped or repeated.
- Latency, with ready held 1: start sampled at cycle 0; rd_en cycles 1..N (N=IMG_W*IMG_H); pix_valid cycles 2..N+1; done at cycle N+2.

Test Plan:
- IMG_W=IMG_H=8, K=5, stride=1, ready=1, start at cycle 0 -> rd_addr 0..63 on cycles 1..64, 16 win_valid beats, first at (win_row 0, win_col 0) on the 37th pix_valid beat (pr=4, pc=4), last at (3,3); done at cycle 66.
- Same map, stride=2 -> 4 windows at (0,0),(0,1),(1,0),(1,1), drawn from pixels (4,4),(4,6),(6,4),(6,6).
- stride=0 -> identical to stride=1, 16 windows.
- ready low for cycles 10..19 in the stride=1 run -> rd_en low for exactly those cycles, one pix_valid at cycle 10, no duplicate or missing addresses, done at cycle 76.
- start re-pulsed at cycle 30 with stride=2 during the stride=1 run -> ignored, still 16 windows, a single done.
- rst asserted at cycle 40 -> all outputs 0 the same cycle, no done; a new start afterwards completes normally with 16 windows.
